// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port 1024x32 RAM between the CPU (port 0) and a secondary
// requester. Optional burst locking is built only when MEM_ARB_LOCK_EN is defined.
module mem_arbiter #(
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [9:0]  addr0,
    input  logic [9:0]  addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout,
    input  logic        cnt_clr,
    output logic [15:0] gcnt0,
    output logic [15:0] gcnt1,
    output logic [15:0] ccnt
);

    logic        last_q;
    logic        rd_q;
    logic        rd_port_q;
    logic [15:0] gcnt0_q;
    logic [15:0] gcnt1_q;
    logic [15:0] ccnt_q;
    logic        pick1;

`ifdef MEM_ARB_LOCK_EN
    localparam logic [3:0] BurstMax = 4'(MAX_BURST);

    logic       locked_q;
    logic       locked_d;
    logic [3:0] burst_q;
    logic [3:0] burst_d;
`else
    logic       unused_lock;
    logic [3:0] unused_cfg;

    assign unused_lock = lock0 ^ lock1;
    assign unused_cfg  = 4'(MAX_BURST);
`endif

    // pick1 only matters when both ports request.
    always_comb begin
        pick1 = (PRIO_MODE != 0) ? 1'b0 : ~last_q;
`ifdef MEM_ARB_LOCK_EN
        if (locked_q) begin
            pick1 = (burst_q < BurstMax) ? last_q : ~last_q;
        end
`endif
        gnt0 = ~rst & req0 & (~req1 | ~pick1);
        gnt1 = ~rst & req1 & (~req0 | pick1);
    end

    always_comb begin
        ram_addr = 10'd0;
        ram_din  = 32'd0;
        ram_we   = 1'b0;
        if (gnt0) begin
            ram_addr = addr0;
            ram_din  = wdata0;
            ram_we   = we0;
        end else if (gnt1) begin
            ram_addr = addr1;
            ram_din  = wdata1;
            ram_we   = we1;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    // Burst count tracks consecutive locked grants to the port held in last_q.
    always_comb begin
        locked_d = locked_q;
        burst_d  = burst_q;
        if (gnt0 | gnt1) begin
            if (gnt1 ? lock1 : lock0) begin
                locked_d = 1'b1;
                if (locked_q && (gnt1 == last_q)) begin
                    burst_d = (burst_q < BurstMax) ? burst_q + 4'd1 : burst_q;
                end else begin
                    burst_d = 4'd1;
                end
            end else begin
                locked_d = 1'b0;
                burst_d  = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= 1'b0;
            burst_q  <= 4'd0;
        end else begin
            locked_q <= locked_d;
            burst_q  <= burst_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b1;
            rd_q      <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            if (gnt0 | gnt1) begin
                last_q <= gnt1;
            end
            rd_q      <= (gnt0 & ~we0) | (gnt1 & ~we1);
            rd_port_q <= gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            gcnt0_q <= 16'd0;
            gcnt1_q <= 16'd0;
            ccnt_q  <= 16'd0;
        end else begin
            if (gnt0 && gcnt0_q != 16'hFFFF) begin
                gcnt0_q <= gcnt0_q + 16'd1;
            end
            if (gnt1 && gcnt1_q != 16'hFFFF) begin
                gcnt1_q <= gcnt1_q + 16'd1;
            end
            if (req0 && req1 && ccnt_q != 16'hFFFF) begin
                ccnt_q <= ccnt_q + 16'd1;
            end
        end
    end

    // A return tag captured just before reset is suppressed while rst is high.
    assign rvalid0 = ~rst & rd_q & ~rd_port_q;
    assign rvalid1 = ~rst & rd_q & rd_port_q;
    assign rdata   = (rvalid0 | rvalid1) ? ram_dout : 32'd0;
    assign gcnt0   = gcnt0_q;
    assign gcnt1   = gcnt1_q;
    assign ccnt    = ccnt_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 1024×32 data RAM between the CPU data path (port 0) and a secondary requester such as a program loader or debug port (port 1). It sits between the memory/IO bus decoder and the RAM.
- Grants at most one access per clock, using either round-robin or fixed CPU priority.
- Returns read data one cycle after the grant, tagged to the owning port.
- Keeps saturating usage counters that the bus can expose for performance display.

## Interface
Parameters:
- PRIO_MODE, 0: arbitration policy; 0 = round-robin, 1 = port 0 always wins.
- MAX_BURST, 4: maximum consecutive locked grants to one port (range 1..15); used only with the lock feature.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0 / req1  in  1  request valid; held with its command until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  10  RAM word address.
- wdata0 / wdata1  in  32  write data.
- lock0 / lock1  in  1  burst-lock request; honoured only when MEM_ARB_LOCK_EN is defined.
- gnt0 / gnt1  out  1  grant; a transfer occurs in any cycle where reqN && gntN.
- rvalid0 / rvalid1  out  1  read data valid for port N.
- rdata  out  32  read data; meaningful only while an rvalid is high.
- ram_addr  out  10  RAM address.
- ram_din  out  32  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  RAM read data; valid one cycle after the address is presented.
- cnt_clr  in  1  synchronous clear of the usage counters.
- gcnt0 / gcnt1  out  16  saturating grant counts per port.
- ccnt  out  16  saturating count of contention cycles (req0 && req1).

## Operation
- Arbitration is combinational on the current req0/req1 and the registered state. At most one gnt is high per cycle. No request means no grant.
- Grant policy:
  - Only one port requesting: that port wins.
  - Both requesting, PRIO_MODE=1: port 0 wins.
  - Both requesting, PRIO_MODE=0: the port that is not `last` wins.
- `last` is a 1-bit register updated to the winner on every transfer.
- RAM mux: ram_addr, ram_din and ram_we follow the winning port's addr, wdata and we.
  - ram_we = weN && gntN.
  - With no grant: ram_addr=0, ram_din=0, ram_we=0.
- Read return: a registered tag records (read granted, owner). In the next cycle:
  - the matching rvalidN pulses for one cycle;
  - rdata = ram_dout, registered through to the output.
  - Writes never produce rvalid.
- Counters:
  - gcntN increments on each port-N transfer.
  - ccnt increments on each cycle with both req high.
  - Each counter stops at 16'hFFFF.
  - cnt_clr zeroes all three counters; if cnt_clr coincides with an increment, clear wins.
- Reset values:
  - gnt0/1=0 (forced low during rst), rvalid0/1=0, rdata=0, ram_we=0, ram_addr=0, ram_din=0.
  - last=1, so port 0 wins the first tie.
  - burst count=0; gcnt0/gcnt1/ccnt=0.
- Reset with requests pending: no grant, no RAM write, and any pending rvalid is dropped.

## Timing
- Cycle N, request granted: RAM address and data driven.
- Cycle N+1: rvalid and rdata presented. Read latency is exactly 1 cycle.
- Throughput: one transfer per cycle, with back-to-back grants to the same or alternating ports.
- Round-robin with both ports requesting continuously: grants alternate every cycle (0,1,0,1… after reset).
- Requester rule: req, we, addr and wdata stay stable while req=1 and gnt=0. After gnt, the requester drops req or presents the next command in the following cycle.
- The arbiter never deasserts a grant mid-cycle and never grants without req.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - If the current winner's lockN is high during a transfer, the winner keeps priority over the round-robin/fixed choice in the next cycle.
  - A 4-bit burst counter counts consecutive locked grants to the same owner.
  - After MAX_BURST consecutive locked grants, the next contention cycle is granted to the other port and the counter resets to 0.
  - The counter also resets whenever the owner changes or lock is low.
  - With no contention, a locked port keeps receiving grants indefinitely.
- MEM_ARB_LOCK_EN undefined:
  - lock0/lock1 are ignored and the burst counter is not built.
  - Behaviour is exactly the base policy.

## Test plan
- Reset, then req0 read at addr 10 with RAM[10]=32'hDEADBEEF → gnt0 same cycle; next cycle rvalid0=1, rdata=32'hDEADBEEF, rvalid1=0.
- PRIO_MODE=0, both ports requesting reads for 6 cycles → grant sequence 0,1,0,1,0,1; ccnt=6, gcnt0=3, gcnt1=3.
- PRIO_MODE=1, both ports requesting for 5 cycles → gnt0 every cycle, gnt1=0; after req0 drops, gnt1 in that same cycle.
- Write 32'h12345678 to addr 3 via port 1, then read addr 3 via port 0 in the next cycle → ram_we=1 only in the write cycle; rvalid0 with 32'h12345678.
- MEM_ARB_LOCK_EN, MAX_BURST=4, lock0=1, both requesting → gnt0 ×4, then gnt1 ×1, then gnt0 resumes; without the macro the grants alternate.
- rst asserted while both ports request, and gcnt0 preset to 16'hFFFF before the rst → no grants during rst, all outputs at reset values; separately, gcnt0 at 16'hFFFF stays there after further grants, and cnt_clr returns it to 0.
